// File: rtl/mole_spawner.sv
// mole_spawner: the mole/timer responder for the whac-a-mole game FSM.
// Each rising edge of ready_for_mole picks a pseudo-random mole from a
// free-running LFSR and never repeats the current one. While timeout_start
// is held, a per-level hit window counts down in millisecond ticks, and
// timeout is driven low when the window runs out.
// Optional build macro MOLE_SPEEDUP_EN makes the window shorter as the game
// goes on: every 8th pick removes 1/8 of the base window, and the window
// never drops below half of the base.
module mole_spawner #(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned NUM_MOLES    = 18,
  parameter int unsigned LVL1_MS      = 1500,
  parameter int unsigned LVL2_MS      = 1000,
  parameter int unsigned LVL3_MS      = 600,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready_for_mole,
  input  logic        timeout_start,
  input  logic [1:0]  level_number,
  output logic [17:0] led_number,
  output logic [4:0]  mole_index,
  output logic        timeout,
  output logic [11:0] time_left_ms
);

  // Only the low 12 bits of a window are kept. A window of 0 ms becomes 1 ms.
  function automatic logic [11:0] fix_window(input int unsigned ms);
    logic [11:0] t;
    t = ms[11:0];
    return (t == 12'd0) ? 12'd1 : t;
  endfunction

  // The all-zero state would lock up the LFSR, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int unsigned PW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);
  localparam logic [4:0]  LAST_IDX  = 5'(NUM_MOLES - 1);
  localparam logic [11:0] WIN1      = fix_window(LVL1_MS);
  localparam logic [11:0] WIN2      = fix_window(LVL2_MS);
  localparam logic [11:0] WIN3      = fix_window(LVL3_MS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_EXPIRED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   time_left_q, time_left_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          rfm_q, rfm_d;
  logic [4:0]    mole_index_q, mole_index_d;
  logic [17:0]   led_q, led_d;

  logic          pick_fire;
  logic [4:0]    cand;
  logic [11:0]   base_win;
  logic [11:0]   eff_win;

  // Select the base window for the level. Only the load edge uses it.
  always_comb begin
    unique case (level_number)
      2'd2:    base_win = WIN2;
      2'd3:    base_win = WIN3;
      default: base_win = WIN1;
    endcase
  end

`ifdef MOLE_SPEEDUP_EN
  logic [3:0]  pick_cnt_q, pick_cnt_d;
  logic [11:0] offset_q, offset_d;
  logic [1:0]  level_prev_q, level_prev_d;
  logic [12:0] offset_sum;
  logic [11:0] offset_cap;
  logic [11:0] win_diff;

  // Speed-up bookkeeping: count the picks, and grow the offset on every 8th
  // pick. Both reset whenever the level changes.
  always_comb begin
    pick_cnt_d   = pick_cnt_q;
    offset_d     = offset_q;
    level_prev_d = level_number;
    offset_cap   = base_win - (base_win >> 1);
    offset_sum   = {1'b0, offset_q} + {1'b0, base_win >> 3};
    if (level_number != level_prev_q) begin
      pick_cnt_d = 4'd0;
      offset_d   = 12'd0;
    end else if (pick_fire) begin
      pick_cnt_d = pick_cnt_q + 4'd1;
      if (pick_cnt_d[2:0] == 3'd0) begin
        offset_d = (offset_sum > {1'b0, offset_cap}) ? offset_cap : offset_sum[11:0];
      end
    end
    win_diff = base_win - offset_q;
    eff_win  = (win_diff == 12'd0) ? 12'd1 : win_diff;
  end

  // Speed-up state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pick_cnt_q   <= 4'd0;
      offset_q     <= 12'd0;
      level_prev_q <= 2'd0;
    end else begin
      pick_cnt_q   <= pick_cnt_d;
      offset_q     <= offset_d;
      level_prev_q <= level_prev_d;
    end
  end
`else
  assign eff_win = base_win;
`endif

  // Step the LFSR every cycle, detect a rising edge on ready_for_mole, and
  // choose the next mole. If the candidate equals the current mole, take the
  // following index instead.
  // NOTE: every signal assigned in an always_comb gets a default value first. A path that assigns nothing would infer a latch.
  always_comb begin
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rfm_d        = ready_for_mole;
    pick_fire    = ready_for_mole & ~rfm_q;
    mole_index_d = mole_index_q;
    led_d        = led_q;
    cand         = 5'(lfsr_q % 16'(NUM_MOLES));
    if (pick_fire) begin
      if (cand == mole_index_q) begin
        mole_index_d = (cand == LAST_IDX) ? 5'd0 : cand + 5'd1;
      end else begin
        mole_index_d = cand;
      end
      led_d = 18'd1 << mole_index_d;
    end
  end

  // Hit-window timer: load the window, count ms ticks down, report expiry.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    time_left_d = time_left_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        timeout_d   = 1'b1;
        time_left_d = 12'd0;
        presc_d     = '0;
        if (timeout_start) begin
          time_left_d = eff_win;
          state_d     = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!timeout_start) begin
          state_d     = S_IDLE;
          timeout_d   = 1'b1;
          time_left_d = 12'd0;
          presc_d     = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (time_left_q <= 12'd1) begin
            time_left_d = 12'd0;
            timeout_d   = 1'b0;
            state_d     = S_EXPIRED;
          end else begin
            time_left_d = time_left_q - 12'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_EXPIRED: begin
        timeout_d   = 1'b0;
        time_left_d = 12'd0;
        presc_d     = '0;
        if (!timeout_start) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        timeout_d   = 1'b1;
        time_left_d = 12'd0;
        presc_d     = '0;
      end
    endcase
  end

  // State registers. An asynchronous reset returns the block to idle at once.
  // NOTE: sequential state uses non-blocking assignments only. Every flop then samples its pre-edge inputs, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      time_left_q  <= 12'd0;
      timeout_q    <= 1'b1;
      lfsr_q       <= SEED_EFF;
      rfm_q        <= 1'b0;
      mole_index_q <= 5'd0;
      led_q        <= 18'd0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_left_q  <= time_left_d;
      timeout_q    <= timeout_d;
      lfsr_q       <= lfsr_d;
      rfm_q        <= rfm_d;
      mole_index_q <= mole_index_d;
      led_q        <= led_d;
    end
  end

  assign led_number   = led_q;
  assign mole_index   = mole_index_q;
  assign timeout      = timeout_q;
  assign time_left_ms = time_left_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Testbench for mole_spawner, built with small timing parameters.
// Stimulus tasks push the expected mole picks and timeout-fall cycles into
// queues. A monitor running on the falling clock edge pops and compares them.
module tb_mole_spawner;

  localparam int TPM = 2;
  localparam int NM  = 18;
  localparam int L1  = 10;
  localparam int L2  = 8;
  localparam int L3  = 6;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready_for_mole = 1'b0;
  logic        timeout_start = 1'b0;
  logic [1:0]  level_number = 2'd0;
  logic [17:0] led_number;
  logic [4:0]  mole_index;
  logic        timeout;
  logic [11:0] time_left_ms;

  int checks = 0;
  int errors = 0;
  int unsigned cyc;

  int pick_q[$];
  int fall_q[$];

  logic [15:0] m_lfsr = SEED;
  int unsigned m_n = 0;
  int          m_last = 0;

  logic [17:0] prev_led = 18'd0;
  logic        prev_to = 1'b1;
  bit          seen[NM];

  mole_spawner #(
    .TICKS_PER_MS(TPM),
    .NUM_MOLES(NM),
    .LVL1_MS(L1),
    .LVL2_MS(L2),
    .LVL3_MS(L3),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ready_for_mole(ready_for_mole),
    .timeout_start(timeout_start),
    .level_number(level_number),
    .led_number(led_number),
    .mole_index(mole_index),
    .timeout(timeout),
    .time_left_ms(time_left_ms)
  );

  always #5 clk = ~clk;

  // Count the clock edges since reset was released. The LFSR steps once per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int win_ms(input logic [1:0] lvl);
    case (lvl)
      2'd2:    return L2;
      2'd3:    return L3;
      default: return L1;
    endcase
  endfunction

  // Reference pick: advance the LFSR to the edge that samples the request, then
  // take the value mod NM. If that equals the current mole, take the next index.
  task automatic predict_pick();
    int cand;
    while (m_n < cyc) begin
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      m_n++;
    end
    cand = int'(m_lfsr) % NM;
    if (cand == m_last) cand = (cand + 1) % NM;
    m_last = cand;
    pick_q.push_back(cand);
  endtask

  task automatic reset_model();
    pick_q.delete();
    fall_q.delete();
    m_lfsr = SEED;
    m_n    = 0;
    m_last = 0;
  endtask

  task automatic pulse_mole(input int high_cycles, input int low_cycles);
    @(negedge clk);
    predict_pick();
    ready_for_mole = 1'b1;
    repeat (high_cycles) @(negedge clk);
    ready_for_mole = 1'b0;
    repeat (low_cycles) @(negedge clk);
  endtask

  // Hold timeout_start for 'hold' edges, then check every cycle against
  // arithmetic on the window length.
  task automatic run_window(input logic [1:0] lvl, input int hold);
    int w;
    int e;
    logic exp_to;
    int   exp_tl;
    w = win_ms(lvl);
    @(negedge clk);
    level_number  = lvl;
    timeout_start = 1'b1;
    if (hold > w * TPM) fall_q.push_back(int'(cyc) + w * TPM + 1);
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      if (j == hold / 2) level_number = 2'($urandom_range(0, 3));
      e      = j - 1;
      exp_to = (e < w * TPM);
      exp_tl = exp_to ? (w - e / TPM) : 0;
      check("timeout_win", 32'(timeout), 32'(exp_to));
      check("time_left_win", 32'(time_left_ms), 32'(exp_tl));
    end
    timeout_start = 1'b0;
    @(negedge clk);
    check("timeout_idle", 32'(timeout), 32'd1);
    check("time_left_idle", 32'(time_left_ms), 32'd0);
  endtask

  // Monitor: when the displayed mole changes or timeout falls, compare with the queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_led = 18'd0;
      prev_to  = 1'b1;
    end else begin
      if (led_number !== prev_led) begin
        if (pick_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pick_unexpected: got led %0h with no pick pending", led_number);
        end else begin
          automatic int exp_idx = pick_q.pop_front();
          check("pick_index", 32'(mole_index), 32'(exp_idx));
          check("pick_onehot", 32'(led_number), 32'(18'd1 << exp_idx));
          if (exp_idx < NM) seen[exp_idx] = 1'b1;
        end
      end
      prev_led = led_number;
      if (prev_to && !timeout) begin
        if (fall_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fall_unexpected: timeout fell at cycle %0d with no expiry expected", cyc);
        end else begin
          automatic int exp_c = fall_q.pop_front();
          check("fall_cycle", 32'(cyc), 32'(exp_c));
        end
      end
      prev_to = timeout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen;
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_model();
    check("rst_led", 32'(led_number), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd1);
    check("rst_time_left", 32'(time_left_ms), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_led", 32'(led_number), 32'd0);
    check("post_rst_timeout", 32'(timeout), 32'd1);

    // Single-cycle pulse, then a long hold that must not pick again
    pulse_mole(1, 3);
    pulse_mole(20, 2);
    check("hold_no_repick", 32'(mole_index), 32'(m_last));

    // Expiry after exactly W*TPM cycles, then a hit before expiry
    run_window(2'd1, 25);
    run_window(2'd3, 7);

    // Random picks running alongside random windows
    fork
      for (int i = 0; i < 200; i++) pulse_mole(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
      for (int k = 0; k < 30; k++) run_window(2'($urandom_range(0, 3)), int'($urandom_range(1, 26)));
    join
    repeat (3) @(negedge clk);
    n_seen = 0;
    for (int i = 0; i < NM; i++) if (seen[i]) n_seen++;
    check("all_indices_seen", 32'(n_seen), 32'(NM));

    // Async reset in the middle of a window
    @(negedge clk);
    level_number  = 2'd1;
    timeout_start = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    check("pre_async_led_nonzero", 32'(led_number != 18'd0), 32'd1);
    check("pre_async_time_left", 32'(time_left_ms), 32'(L1 - 8 / TPM));
    rst_n = 1'b0;
    #1;
    check("async_timeout", 32'(timeout), 32'd1);
    check("async_led", 32'(led_number), 32'd0);
    check("async_time_left", 32'(time_left_ms), 32'd0);
    timeout_start = 1'b0;
    repeat (2) @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    pulse_mole(1, 3);
    pulse_mole(2, 3);
    repeat (2) @(negedge clk);

    check("pick_queue_drained", 32'(pick_q.size()), 32'd0);
    check("fall_queue_drained", 32'(fall_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
